// File: rtl/reg_file_if.sv
// reg_file_if: bus bundle between the pipeline (WB write port, ID read ports)
// and the general-purpose register file.
//   master : pipeline side; drives write request and read indices, receives data
//   slave  : register file side
// Signals:
//   RegWrite  write enable from MEM/WB
//   writeReg  destination index from MEM/WB
//   wData     write data from MEM/WB
//   readReg1  rs index from ID
//   readReg2  rt index from ID
//   readData1 contents of readReg1
//   readData2 contents of readReg2
interface reg_file_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic                  RegWrite;
  logic [ADDR_WIDTH-1:0] writeReg;
  logic [DATA_WIDTH-1:0] wData;
  logic [ADDR_WIDTH-1:0] readReg1;
  logic [ADDR_WIDTH-1:0] readReg2;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;

  modport master (
    output RegWrite, writeReg, wData, readReg1, readReg2,
    input  readData1, readData2
  );

  modport slave (
    input  RegWrite, writeReg, wData, readReg1, readReg2,
    output readData1, readData2
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: general-purpose register file for the five-stage MIPS core.
// One write port (WB stage) and two combinational read ports (ID stage).
// Register 0 is hardwired to zero.
// Ports:
//   clk    single clock, rising edge
//   rst_n  synchronous active-low reset; clears every register
//   bus    reg_file_if.slave (RegWrite/writeReg/wData, readReg1/2, readData1/2)
// Build option:
//   REGFILE_BYPASS_EN  when defined, a read of the register being written in
//                      the current cycle returns wData (WB->ID write-through).
//                      When undefined, reads return stored contents only.
module reg_file #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_file_if.slave       bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  writeHit;
  logic                  bypass1;
  logic                  bypass2;

  // RegWrite is tested first so an unknown writeReg is irrelevant when idle.
  assign writeHit = bus.RegWrite && (bus.writeReg != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (writeHit) begin
      regs[bus.writeReg] <= bus.wData;
    end
  end

`ifdef REGFILE_BYPASS_EN
  // Suppressed while in reset so outputs reflect storage only.
  assign bypass1 = rst_n && writeHit && (bus.writeReg == bus.readReg1);
  assign bypass2 = rst_n && writeHit && (bus.writeReg == bus.readReg2);
`else
  assign bypass1 = 1'b0;
  assign bypass2 = 1'b0;
`endif

  always_comb begin
    bus.readData1 = '0;
    if (bus.readReg1 != '0) begin
      bus.readData1 = bypass1 ? bus.wData : regs[bus.readReg1];
    end
  end

  always_comb begin
    bus.readData2 = '0;
    if (bus.readReg2 != '0) begin
      bus.readData2 = bypass2 ? bus.wData : regs[bus.readReg2];
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file: self-checking bench for reg_file. Directed scenarios plus a
// randomized run, all checked against an array model of the register file.
module tb_reg_file;

`ifdef REGFILE_BYPASS_EN
  localparam bit bypassEn = 1'b1;
`else
  localparam bit bypassEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;

  reg_file_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

  reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  logic [31:0] model [32];

  // Architectural view of a read port given the inputs currently driven.
  function automatic logic [31:0] expRead(input logic [4:0] idx);
    if (idx == 5'd0) return 32'h0;
    if (bypassEn && rst_n === 1'b1 && bus.RegWrite === 1'b1 &&
        bus.writeReg != 5'd0 && bus.writeReg == idx) return bus.wData;
    return model[idx];
  endfunction

  // Advance across one rising edge and apply its effect to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (bus.RegWrite === 1'b1 && bus.writeReg != 5'd0) begin
      model[bus.writeReg] = bus.wData;
    end
    #1;
  endtask

  task automatic idle();
    bus.RegWrite = 1'b0;
    bus.writeReg = 5'd0;
    bus.wData    = 32'h0;
  endtask

  task automatic writeReg(input logic [4:0] idx, input logic [31:0] val);
    bus.RegWrite = 1'b1;
    bus.writeReg = idx;
    bus.wData    = val;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.RegWrite = 1'b1;
    bus.writeReg = 5'd5;
    bus.wData    = 32'hDEADBEEF;
    bus.readReg1 = 5'd5;
    bus.readReg2 = 5'd0;
    tick();
    @(negedge clk);
    compared++;
    if (bus.readData1 !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_no_bypass: got %h expected %h", bus.readData1, 32'h0);
    end
    tick();
    rst_n = 1'b1;
    idle();
    #1;
    compared++;
    if (bus.readData1 !== 32'h0) begin
      mismatched++;
      $display("FAIL reset_r5: got %h expected %h", bus.readData1, 32'h0);
    end
    for (int i = 0; i < 32; i++) begin
      bus.readReg1 = 5'(i);
      bus.readReg2 = 5'(31 - i);
      #1;
      compared++;
      if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
        mismatched++;
        $display("FAIL reset_all idx %0d: got %h/%h expected 0/0", i,
                 bus.readData1, bus.readData2);
      end
    end
  endtask

  task automatic test_basic();
    writeReg(5'd8, 32'h12345678);
    bus.readReg1 = 5'd8;
    bus.readReg2 = 5'd8;
    #1;
    compared++;
    if (bus.readData1 !== 32'h12345678 || bus.readData2 !== 32'h12345678) begin
      mismatched++;
      $display("FAIL basic_r8: got %h/%h expected 12345678", bus.readData1, bus.readData2);
    end
    bus.readReg2 = 5'd9;
    #1;
    compared++;
    if (bus.readData2 !== 32'h0) begin
      mismatched++;
      $display("FAIL basic_r9: got %h expected 0", bus.readData2);
    end
  endtask

  task automatic test_zero();
    bus.readReg1 = 5'd0;
    bus.readReg2 = 5'd0;
    bus.RegWrite = 1'b1;
    bus.writeReg = 5'd0;
    bus.wData    = 32'hFFFFFFFF;
    @(negedge clk);
    compared++;
    if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
      mismatched++;
      $display("FAIL zero_write_cycle: got %h/%h expected 0", bus.readData1, bus.readData2);
    end
    tick();
    idle();
    @(negedge clk);
    compared++;
    if (bus.readData1 !== 32'h0) begin
      mismatched++;
      $display("FAIL zero_after: got %h expected 0", bus.readData1);
    end
  endtask

  task automatic test_hazard();
    logic [31:0] expPre;
    writeReg(5'd3, 32'h11);
    bus.RegWrite = 1'b1;
    bus.writeReg = 5'd3;
    bus.wData    = 32'h22;
    bus.readReg1 = 5'd3;
    bus.readReg2 = 5'd3;
    expPre = bypassEn ? 32'h22 : 32'h11;
    @(negedge clk);
    compared++;
    if (bus.readData1 !== expPre || bus.readData2 !== expPre) begin
      mismatched++;
      $display("FAIL hazard_pre: got %h/%h expected %h", bus.readData1, bus.readData2, expPre);
    end
    tick();
    idle();
    compared++;
    if (bus.readData1 !== 32'h22 || bus.readData2 !== 32'h22) begin
      mismatched++;
      $display("FAIL hazard_post: got %h/%h expected 22", bus.readData1, bus.readData2);
    end
  endtask

  task automatic test_write_disabled();
    writeReg(5'd7, 32'h5);
    bus.RegWrite = 1'b0;
    bus.writeReg = 5'd7;
    bus.wData    = 32'hAAAA;
    bus.readReg1 = 5'd7;
    bus.readReg2 = 5'd7;
    @(negedge clk);
    compared++;
    if (bus.readData1 !== 32'h5 || bus.readData2 !== 32'h5) begin
      mismatched++;
      $display("FAIL wdis_pre: got %h/%h expected 5", bus.readData1, bus.readData2);
    end
    tick();
    bus.writeReg = 'x;
    tick();
    idle();
    compared++;
    if (bus.readData1 !== 32'h5) begin
      mismatched++;
      $display("FAIL wdis_post: got %h expected 5", bus.readData1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expMid;
    bus.readReg1 = 5'd4;
    bus.readReg2 = 5'd1;
    bus.RegWrite = 1'b1;
    bus.writeReg = 5'd4;
    bus.wData    = 32'h1;
    tick();
    bus.wData    = 32'h2;
    expMid = bypassEn ? 32'h2 : 32'h1;
    @(negedge clk);
    compared++;
    if (bus.readData1 !== expMid) begin
      mismatched++;
      $display("FAIL b2b_mid: got %h expected %h", bus.readData1, expMid);
    end
    tick();
    idle();
    compared++;
    if (bus.readData1 !== 32'h2) begin
      mismatched++;
      $display("FAIL b2b_last: got %h expected 2", bus.readData1);
    end
  endtask

  task automatic test_reset_mid();
    writeReg(5'd10, 32'hCAFE0001);
    rst_n = 1'b0;
    bus.RegWrite = 1'b1;
    bus.writeReg = 5'd10;
    bus.wData    = 32'h0BADF00D;
    bus.readReg1 = 5'd10;
    bus.readReg2 = 5'd8;
    @(negedge clk);
    compared++;
    if (bus.readData1 !== 32'hCAFE0001 || bus.readData2 !== 32'h12345678) begin
      mismatched++;
      $display("FAIL rstmid_pre: got %h/%h expected cafe0001/12345678",
               bus.readData1, bus.readData2);
    end
    tick();
    rst_n = 1'b1;
    idle();
    tick();
    compared++;
    if (bus.readData1 !== 32'h0 || bus.readData2 !== 32'h0) begin
      mismatched++;
      $display("FAIL rstmid_post: got %h/%h expected 0/0", bus.readData1, bus.readData2);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2;
    for (int n = 0; n < 400; n++) begin
      rst_n        = ($urandom_range(0, 24) != 0);
      bus.RegWrite = ($urandom_range(0, 2) != 0);
      bus.writeReg = 5'($urandom_range(0, 31));
      bus.wData    = $urandom;
      bus.readReg1 = ($urandom_range(0, 3) == 0) ? bus.writeReg : 5'($urandom_range(0, 31));
      bus.readReg2 = ($urandom_range(0, 3) == 0) ? bus.writeReg : 5'($urandom_range(0, 31));
      @(negedge clk);
      e1 = expRead(bus.readReg1);
      e2 = expRead(bus.readReg2);
      compared++;
      if (bus.readData1 !== e1 || bus.readData2 !== e2) begin
        mismatched++;
        $display("FAIL random cyc %0d idx %0d/%0d: got %h/%h expected %h/%h", n,
                 bus.readReg1, bus.readReg2, bus.readData1, bus.readData2, e1, e2);
      end
      tick();
    end
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    rst_n = 1'b0;
    idle();
    bus.readReg1 = 5'd0;
    bus.readReg2 = 5'd0;
    test_reset();
    test_basic();
    test_zero();
    test_hazard();
    test_write_disabled();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/reg_file.md
# reg_file

General-purpose register file for the five-stage pipelined MIPS core. It is written by the write-back stage directly downstream of the MEM/WB pipeline register, which supplies `RegWrite`, `writeReg` and `wData`. It is read combinationally by the ID stage through two read ports. An optional write-through bypass lets a register written in WB be read by ID in the same cycle.

## Interface
- `DATA_WIDTH`, default 32: register width.
- `ADDR_WIDTH`, default 5: register index width; depth is 2**ADDR_WIDTH (32).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `RegWrite`  in  1  write enable from the MEM/WB register.
- `writeReg`  in  ADDR_WIDTH  destination index from the MEM/WB register.
- `wData`  in  DATA_WIDTH  write data from the MEM/WB register (already muxed ALU/memory result).
- `readReg1`  in  ADDR_WIDTH  rs index from ID.
- `readReg2`  in  ADDR_WIDTH  rt index from ID.
- `readData1`  out  DATA_WIDTH  contents of `readReg1`.
- `readData2`  out  DATA_WIDTH  contents of `readReg2`.

## Operation
- Storage is 2**ADDR_WIDTH registers of DATA_WIDTH bits.
- Register 0 is hardwired to zero:
  - Writes to index 0 are discarded.
  - Reads of index 0 always return 0, including under bypass.
- Write: at a rising edge with `rst_n`=1, `RegWrite`=1 and `writeReg`≠0, `reg[writeReg]` ← `wData`. All other registers hold.
- Read: `readData1`/`readData2` are combinational functions of their index and the current storage, plus the bypass path when enabled.
- The two read ports are independent. Both may address the same register, and both may match `writeReg` simultaneously.
- Reset: at a rising edge with `rst_n`=0, every register is cleared to 0. A concurrent write is ignored; reset wins.
- X/Z on `writeReg` while `RegWrite`=0 has no effect on storage.

## Timing
- Write latency: 1 cycle. The value is visible on a read port (non-bypass path) from the cycle after the write edge.
- Read latency: 0 cycles, combinational from `readRegN`.
- Reset value of outputs:
  - `readData1`=`readData2`=0 from the first cycle after a reset edge, for any index.
  - While `rst_n`=0, the bypass path is suppressed, so outputs reflect storage only.
- Reset mid-operation: a write presented in the same cycle as an asserted `rst_n` is lost. It is not replayed after reset.
- Back-to-back writes to the same index on consecutive edges: the last one wins. Each intermediate value is readable for exactly one cycle.
- There is no handshake or stall input. The pipeline guarantees that `RegWrite` is qualified.

## Configuration
- Macro: `REGFILE_BYPASS_EN`.
- Defined: `readDataN` returns `wData` in the same cycle when all of the following hold:
  - `RegWrite`=1
  - `rst_n`=1
  - `writeReg`≠0
  - `writeReg`=`readRegN`
  
  This resolves the WB→ID hazard with no extra stall; the hazard unit does not stall on a WB/ID match.
- Undefined: reads return stored contents only. The new value appears the cycle after the write. The hazard unit is responsible for the extra stall cycle.

## Test plan
- Reset: hold `rst_n`=0 for 2 edges with `RegWrite`=1, `writeReg`=5, `wData`=0xDEADBEEF; release, then read `readReg1`=5 → 0. Reading indices 0..31 on both ports → all 0.
- Basic write/read: write 0x12345678 to r8 at edge N; at cycle N+1, `readReg1`=8 and `readReg2`=8 → both 0x12345678. r9 still reads 0.
- Zero register: write 0xFFFFFFFF to r0; `readReg1`=0 → 0 in the write cycle and after it, in both macro builds.
- Same-cycle hazard: r3 holds 0x11; drive `RegWrite`=1, `writeReg`=3, `wData`=0x22, `readReg1`=3, `readReg2`=3.
  - With `REGFILE_BYPASS_EN`: both outputs read 0x22 before the edge.
  - Without it: both read 0x11 before the edge and 0x22 after it.
- Write disabled: `RegWrite`=0, `writeReg`=7, `wData`=0xAAAA; r7 unchanged (previous value 0x5 remains). Bypass does not fire.
- Consecutive writes: r4 ← 0x1 at edge N, then r4 ← 0x2 at edge N+1; reads give 0x1 in cycle N+1 and 0x2 in cycle N+2. With bypass, the read in cycle N+1 gives 0x2.
